ram_1w_nr_sync: RTL and testbench

//  Parametrised multi-port RAM: one write port with byte enables, NREAD synchronous read ports.

---
 rtl/ram_1w_nr_sync_if.sv | 26 ++
 rtl/ram_1w_nr_sync.sv | 107 ++++++++++
 tb/tb_ram_1w_nr_sync.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_1w_nr_sync_if.sv
// Bus bundle for ram_1w_nr_sync: one byte-enabled write port plus NREAD
// read ports. master drives requests; slave returns rd_data/rd_valid.
interface ram_1w_nr_sync_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 8,
   parameter int NREAD  = 2
);
   logic                      wr_en;
   logic [AWIDTH-1:0]         wr_addr;
   logic [DWIDTH-1:0]         wr_data;
   logic [DWIDTH/8-1:0]       wr_be;
   logic [NREAD-1:0]          rd_en;
   logic [NREAD*AWIDTH-1:0]   rd_addr;
   logic [NREAD*DWIDTH-1:0]   rd_data;
   logic [NREAD-1:0]          rd_valid;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      input  rd_data, rd_valid
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/ram_1w_nr_sync.sv
// Multi-port RAM: one byte-enabled write port, NREAD registered read ports.
// Ports: clk, rst_n (async, active low), bus (ram_1w_nr_sync_if.slave).
// Read latency is 1 cycle, or 2 with OUT_REG=1; each port has a valid flag.
module ram_1w_nr_sync #(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 8,
   parameter int DEPTH    = 256,
   parameter int NREAD    = 2,
   parameter int RDW_MODE = 0,
   parameter int OUT_REG  = 0
) (
   input logic                 clk,
   input logic                 rst_n,
   ram_1w_nr_sync_if.slave     bus
);
   localparam int NB = DWIDTH / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so the range check never folds to a constant.
   localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

   logic [DWIDTH-1:0] mem [DEPTH];

   logic [NREAD-1:0][AWIDTH-1:0] ra;
   logic [NREAD-1:0][DWIDTH-1:0] rword;
   logic [NREAD-1:0][DWIDTH-1:0] s1_data;
   logic [NREAD-1:0]             s1_valid;
   logic [DWIDTH-1:0]            wr_mask;
   logic                         wr_ok;

   assign ra = bus.rd_addr;

   // Writes are dropped while in reset and when out of range.
   assign wr_ok = bus.wr_en & rst_n &
                  ({1'b0, bus.wr_addr} < DEPTH_W);

   always_comb begin
      wr_mask = '0;
      for (int i = 0; i < NB; i++) begin
         wr_mask[8*i +: 8] = {8{bus.wr_be[i]}};
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[bus.wr_addr[IW-1:0]] <=
            (mem[bus.wr_addr[IW-1:0]] & ~wr_mask) |
            (bus.wr_data & wr_mask);
      end
   end

   // Word seen by each read port at this edge. The array read happens
   // before the write commits, so read-first falls out naturally; the
   // write-first case forwards the merged word.
   always_comb begin
      logic [DWIDTH-1:0] old;
      rword = '0;
      for (int p = 0; p < NREAD; p++) begin
         old = '0;
         if ({1'b0, ra[p]} < DEPTH_W) begin
            old = mem[ra[p][IW-1:0]];
         end
         rword[p] = old;
         if (RDW_MODE != 0 && wr_ok && bus.wr_addr == ra[p]) begin
            rword[p] = (old & ~wr_mask) | (bus.wr_data & wr_mask);
         end
      end
   end

   // Stage 1: data holds its last value when the port is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data  <= '0;
         s1_valid <= '0;
      end else begin
         s1_valid <= bus.rd_en;
         for (int p = 0; p < NREAD; p++) begin
            if (bus.rd_en[p]) begin
               s1_data[p] <= rword[p];
            end
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [NREAD-1:0][DWIDTH-1:0] s2_data;
         logic [NREAD-1:0]             s2_valid;

         // Loads every cycle; s1 already holds data on idle cycles.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_data  <= '0;
               s2_valid <= '0;
            end else begin
               s2_data  <= s1_data;
               s2_valid <= s1_valid;
            end
         end

         assign bus.rd_data  = s2_data;
         assign bus.rd_valid = s2_valid;
      end else begin : g_no_out_reg
         assign bus.rd_data  = s1_data;
         assign bus.rd_valid = s1_valid;
      end
   endgenerate
endmodule

// File: tb/tb_ram_1w_nr_sync.sv
// Bench for ram_1w_nr_sync: two instances (read-first/latency 1 and
// write-first/latency 2) driven in lockstep and checked against a model.
module tb_ram_1w_nr_sync;
   localparam int ME = 1024;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ram_1w_nr_sync_if #(.DWIDTH(32), .AWIDTH(8), .NREAD(2)) bus_a ();
   ram_1w_nr_sync_if #(.DWIDTH(32), .AWIDTH(8), .NREAD(2)) bus_b ();

   assign bus_b.wr_en   = bus_a.wr_en;
   assign bus_b.wr_addr = bus_a.wr_addr;
   assign bus_b.wr_data = bus_a.wr_data;
   assign bus_b.wr_be   = bus_a.wr_be;
   assign bus_b.rd_en   = bus_a.rd_en;
   assign bus_b.rd_addr = bus_a.rd_addr;

   ram_1w_nr_sync #(
      .DWIDTH(32), .AWIDTH(8), .DEPTH(200), .NREAD(2),
      .RDW_MODE(0), .OUT_REG(0)
   ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

   ram_1w_nr_sync #(
      .DWIDTH(32), .AWIDTH(8), .DEPTH(200), .NREAD(2),
      .RDW_MODE(1), .OUT_REG(1)
   ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   // Reference: word array plus, per edge, what each port was asked for
   // and the word it should be showing (held across idle cycles).
   logic [31:0] mem_m [256];
   logic        ven  [0:ME-1][0:1];
   logic [31:0] h_old[0:ME-1][0:1];
   logic [31:0] h_new[0:ME-1][0:1];
   int n;
   int n_cmp;
   int n_bad;

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [3:0]  be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rda(input int p);
      return bus_a.rd_data[p*32 +: 32];
   endfunction

   function automatic logic [31:0] rdb(input int p);
      return bus_b.rd_data[p*32 +: 32];
   endfunction

   task automatic drive(input logic we, input logic [7:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [1:0] ren, input logic [7:0] a0,
                        input logic [7:0] a1);
      bus_a.wr_en   = we;
      bus_a.wr_addr = wa;
      bus_a.wr_data = wd;
      bus_a.wr_be   = be;
      bus_a.rd_en   = ren;
      bus_a.rd_addr = {a1, a0};
   endtask

   task automatic idle();
      drive(1'b0, 8'h0, 32'h0, 4'h0, 2'b00, 8'h0, 8'h0);
   endtask

   // One clock edge: predict, clock, then compare both instances.
   // Latency-1 instance shows edge n; latency-2 instance shows edge n-1.
   task automatic step();
      logic [7:0]  a;
      logic [31:0] old;
      logic [31:0] nw;
      logic        en;
      logic        hit;
      n++;
      for (int p = 0; p < 2; p++) begin
         a   = bus_a.rd_addr[p*8 +: 8];
         en  = rst_n && bus_a.rd_en[p];
         old = (a < 8'd200) ? mem_m[a] : 32'h0;
         hit = rst_n && bus_a.wr_en && (bus_a.wr_addr == a) &&
               (a < 8'd200);
         nw  = hit ? merge(old, bus_a.wr_data, bus_a.wr_be) : old;
         ven[n][p]   = en;
         h_old[n][p] = !rst_n ? 32'h0 : en ? old : h_old[n-1][p];
         h_new[n][p] = !rst_n ? 32'h0 : en ? nw  : h_new[n-1][p];
      end
      if (rst_n && bus_a.wr_en && bus_a.wr_addr < 8'd200)
         mem_m[bus_a.wr_addr] = merge(mem_m[bus_a.wr_addr],
                                      bus_a.wr_data, bus_a.wr_be);
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("a_valid%0d_e%0d", p, n),
             64'(bus_a.rd_valid[p]), 64'(ven[n][p]));
         chk($sformatf("a_data%0d_e%0d", p, n),
             64'(rda(p)), 64'(h_old[n][p]));
         chk($sformatf("b_valid%0d_e%0d", p, n),
             64'(bus_b.rd_valid[p]), 64'(ven[n-1][p]));
         chk($sformatf("b_data%0d_e%0d", p, n),
             64'(rdb(p)), 64'(h_new[n-1][p]));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] wa;
      logic [7:0] ra0;
      logic [7:0] ra1;
      int r;
      n = 0;
      n_cmp = 0;
      n_bad = 0;
      for (int p = 0; p < 2; p++) begin
         ven[0][p]   = 1'b0;
         h_old[0][p] = 32'h0;
         h_new[0][p] = 32'h0;
      end
      rst_n = 1'b0;
      idle();
      #1;
      chk("rst_valid_a", 64'(bus_a.rd_valid), 64'h0);
      chk("rst_data_a", 64'(bus_a.rd_data), 64'h0);
      chk("rst_valid_b", 64'(bus_b.rd_valid), 64'h0);
      chk("rst_data_b", 64'(bus_b.rd_data), 64'h0);

      // Reads requested during reset must not be acknowledged.
      drive(1'b0, 8'h0, 32'h0, 4'h0, 2'b11, 8'h10, 8'h20);
      step();
      step();
      rst_n = 1'b1;

      for (int a = 0; a < 200; a++) begin
         drive(1'b1, 8'(a), $urandom, 4'hF, 2'b00, 8'h0, 8'h0);
         step();
      end

      // T1 plain write then read
      drive(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 2'b00, 8'h0, 8'h0);
      step();
      drive(1'b0, 8'h0, 32'h0, 4'h0, 2'b01, 8'h10, 8'h0);
      step();
      chk("t1_data_a", 64'(rda(0)), 64'hDEADBEEF);
      chk("t1_valid_a", 64'(bus_a.rd_valid[0]), 64'h1);
      chk("t1_valid_b_early", 64'(bus_b.rd_valid[0]), 64'h0);
      idle();
      step();
      chk("t1_data_b", 64'(rdb(0)), 64'hDEADBEEF);
      chk("t1_valid_b", 64'(bus_b.rd_valid[0]), 64'h1);
      chk("t1_hold_a", 64'(rda(0)), 64'hDEADBEEF);
      chk("t1_idle_a", 64'(bus_a.rd_valid[0]), 64'h0);

      // T2 byte enables
      drive(1'b1, 8'h20, 32'h11223344, 4'hF, 2'b00, 8'h0, 8'h0);
      step();
      drive(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, 2'b00, 8'h0, 8'h0);
      step();
      drive(1'b0, 8'h0, 32'h0, 4'h0, 2'b10, 8'h0, 8'h20);
      step();
      chk("t2_data_a", 64'(rda(1)), 64'h11BB33DD);

      // T3 read-during-write, full and partial byte enables
      drive(1'b1, 8'h30, 32'h1, 4'hF, 2'b00, 8'h0, 8'h0);
      step();
      drive(1'b1, 8'h30, 32'h2, 4'hF, 2'b01, 8'h30, 8'h0);
      step();
      chk("t3_rdw_old_a", 64'(rda(0)), 64'h1);
      drive(1'b1, 8'h30, 32'hAABBCCDD, 4'b0110, 2'b11, 8'h30, 8'h30);
      step();
      chk("t3_rdw_new_b", 64'(rdb(0)), 64'h2);
      chk("t3_part_a0", 64'(rda(0)), 64'h2);
      chk("t3_part_a1", 64'(rda(1)), 64'h2);
      idle();
      step();
      chk("t3_part_b0", 64'(rdb(0)), 64'h00BBCC02);
      chk("t3_part_b1", 64'(rdb(1)), 64'h00BBCC02);

      // T4 two ports, two-cycle latency, enable pattern 1,0,1
      drive(1'b0, 8'h0, 32'h0, 4'h0, 2'b11, 8'h10, 8'h20);
      step();
      chk("t4_v_e1", 64'(bus_b.rd_valid), 64'h0);
      drive(1'b0, 8'h0, 32'h0, 4'h0, 2'b00, 8'h10, 8'h20);
      step();
      chk("t4_v_e2", 64'(bus_b.rd_valid), 64'h3);
      chk("t4_d0", 64'(rdb(0)), 64'hDEADBEEF);
      chk("t4_d1", 64'(rdb(1)), 64'h11BB33DD);
      drive(1'b0, 8'h0, 32'h0, 4'h0, 2'b11, 8'h10, 8'h20);
      step();
      chk("t4_v_e3", 64'(bus_b.rd_valid), 64'h0);
      idle();
      step();
      chk("t4_v_e4", 64'(bus_b.rd_valid), 64'h3);

      // T5 out-of-range write and read at the same edge
      drive(1'b1, 8'd250, 32'h12345678, 4'hF, 2'b11, 8'd250, 8'd250);
      step();
      chk("t5_valid_a", 64'(bus_a.rd_valid), 64'h3);
      chk("t5_data_a", 64'(bus_a.rd_data), 64'h0);
      idle();
      step();
      chk("t5_valid_b", 64'(bus_b.rd_valid), 64'h3);
      chk("t5_data_b", 64'(bus_b.rd_data), 64'h0);

      // T6 reset with a read in flight
      drive(1'b0, 8'h0, 32'h0, 4'h0, 2'b01, 8'h10, 8'h0);
      step();
      rst_n = 1'b0;
      for (int p = 0; p < 2; p++) begin
         ven[n][p]   = 1'b0;
         h_old[n][p] = 32'h0;
         h_new[n][p] = 32'h0;
      end
      #1;
      chk("t6_valid_a", 64'(bus_a.rd_valid), 64'h0);
      chk("t6_data_a", 64'(bus_a.rd_data), 64'h0);
      chk("t6_valid_b", 64'(bus_b.rd_valid), 64'h0);
      chk("t6_data_b", 64'(bus_b.rd_data), 64'h0);
      drive(1'b1, 8'h10, 32'h0BADF00D, 4'hF, 2'b11, 8'h10, 8'h10);
      step();
      step();
      rst_n = 1'b1;
      idle();
      step();
      chk("t6_post_b", 64'(bus_b.rd_valid), 64'h0);
      drive(1'b0, 8'h0, 32'h0, 4'h0, 2'b01, 8'h10, 8'h0);
      step();
      chk("t6_keep_a", 64'(rda(0)), 64'hDEADBEEF);
      idle();
      step();
      chk("t6_keep_b", 64'(rdb(0)), 64'hDEADBEEF);

      // Random traffic with frequent address collisions
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 9);
         if (r < 2)      wa = 8'($urandom_range(200, 255));
         else if (r < 6) wa = 8'($urandom_range(0, 7));
         else            wa = 8'($urandom_range(0, 199));
         r = $urandom_range(0, 9);
         ra0 = (r < 4) ? wa : 8'($urandom_range(0, 255));
         r = $urandom_range(0, 9);
         ra1 = (r < 3) ? wa : (r < 5) ? ra0 : 8'($urandom_range(0, 7));
         drive(1'($urandom_range(0, 1)), wa, $urandom,
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               ra0, ra1);
         step();
      end
      idle();
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
